// File: rtl/slc3_stim_sequencer.sv
// ---------------------------------------------------------------------------
// slc3_stim_sequencer
//
// Script-driven stimulus sequencer for the SLC-3 board top level. A small
// script memory holds entries {op[2:0], arg[DATA_W-1:0]}. The sequencer
// replays them to drive the switch value, pulse the active-low Run/Continue
// buttons, wait, and compare an observed bus against expected values. It
// keeps saturating pass/fail counts.
//
// Opcodes: 0 END, 1 WAIT, 2 SET_SW, 3 PULSE_CONT, 4 PULSE_RUN, 5 CHECK,
//          6-7 illegal (counted as a failure, sets err, ends the run).
//
// Ports:
//   Clk, Reset        clock and synchronous active-low reset
//   wr_en/wr_addr/    script write port, accepted only when not busy
//   wr_data
//   start             begin a run from entry 0, accepted only when not busy
//   obs               observed value compared by CHECK
//   S_out             switch value driven to the SLC-3
//   Run_n, Continue_n active-low buttons, idle high
//   busy, done, err   run status
//   pass_cnt,fail_cnt saturating CHECK counters
//   step_idx          index of the entry being executed
//
// Optional feature, macro STIM_FAIL_CAPTURE_EN:
//   adds fail_idx/fail_obs, holding the step index and obs value of the
//   first failure of a run (illegal op captures its index with obs = 0).
// ---------------------------------------------------------------------------
module slc3_stim_sequencer #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 64,
  parameter int PULSE_LEN = 10,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W+2:0] wr_data,
  input  logic              start,
  input  logic [DATA_W-1:0] obs,
  output logic [DATA_W-1:0] S_out,
  output logic              Run_n,
  output logic              Continue_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        pass_cnt,
  output logic [7:0]        fail_cnt,
  output logic [ADDR_W-1:0] step_idx
`ifdef STIM_FAIL_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [DATA_W-1:0] fail_obs
`endif
);

  localparam logic [2:0] OP_END        = 3'd0;
  localparam logic [2:0] OP_WAIT       = 3'd1;
  localparam logic [2:0] OP_SET_SW     = 3'd2;
  localparam logic [2:0] OP_PULSE_CONT = 3'd3;
  localparam logic [2:0] OP_PULSE_RUN  = 3'd4;
  localparam logic [2:0] OP_CHECK      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_PULSE,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W+2:0] mem [DEPTH];
  logic [DATA_W+2:0] entry_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] cnt_q;

  logic [2:0]        op;
  logic [DATA_W-1:0] arg;
  logic              idle_like;
  logic              accept_start;
  logic              last_step;

  // Decoded control strobes from the next-state logic.
  logic step_done;
  logic pc_inc;
  logic do_set;
  logic do_check;
  logic do_illegal;
  logic cnt_load;
  logic cnt_dec;
  logic run_lo;
  logic cont_lo;
  logic btn_release;

  assign op           = entry_q[DATA_W+2:DATA_W];
  assign arg          = entry_q[DATA_W-1:0];
  assign idle_like    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept_start = start && idle_like;
  assign last_step    = (pc_q == ADDR_W'(DEPTH - 1));

  assign busy     = !idle_like;
  assign done     = (state_q == S_DONE);
  assign step_idx = pc_q;

  // Script memory. Writes are gated off while a run is in progress, so the
  // entry being fetched can never change underneath the sequencer.
  // NOTE: the script RAM has no reset so it maps onto block RAM and a
  // loaded script survives a board reset.
  always_ff @(posedge Clk) begin
    if (wr_en && idle_like) mem[wr_addr] <= wr_data;
    if (state_q == S_FETCH) entry_q <= mem[pc_q];
  end

  // State register.
  // NOTE: every clocked assignment is non-blocking so all registers update
  // together from the values present before the edge.
  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control decode.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    step_done   = 1'b0;
    pc_inc      = 1'b0;
    do_set      = 1'b0;
    do_check    = 1'b0;
    do_illegal  = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    run_lo      = 1'b0;
    cont_lo     = 1'b0;
    btn_release = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_FETCH;
      S_FETCH:        state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_END:  state_d = S_DONE;
          OP_WAIT: begin
            if (arg == '0) begin
              step_done = 1'b1;
            end else begin
              cnt_load = 1'b1;
              state_d  = S_WAIT;
            end
          end
          OP_SET_SW: begin
            do_set    = 1'b1;
            step_done = 1'b1;
          end
          OP_PULSE_CONT: begin
            cont_lo  = 1'b1;
            cnt_load = 1'b1;
            state_d  = S_PULSE;
          end
          OP_PULSE_RUN: begin
            run_lo   = 1'b1;
            cnt_load = 1'b1;
            state_d  = S_PULSE;
          end
          OP_CHECK: begin
            do_check  = 1'b1;
            step_done = 1'b1;
          end
          default: begin
            do_illegal = 1'b1;
            state_d    = S_DONE;
          end
        endcase
      end
      // The counter is loaded with n and the step ends on the cycle it
      // reads 1, giving exactly n cycles in WAIT/PULSE.
      S_WAIT: begin
        if (cnt_q == DATA_W'(1)) step_done = 1'b1;
        else                     cnt_dec   = 1'b1;
      end
      S_PULSE: begin
        if (cnt_q == DATA_W'(1)) begin
          btn_release = 1'b1;
          step_done   = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The last script entry acts as an implicit END; pc never wraps.
    if (step_done) begin
      if (last_step) begin
        state_d = S_DONE;
      end else begin
        pc_inc  = 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic check_fail;
  assign check_fail = do_check && (obs != arg);

  // Datapath registers. Buttons are registered so they are glitch-free and
  // go low the cycle after EXEC, and return high on the edge a reset lands.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_q       <= '0;
      cnt_q      <= '0;
      S_out      <= '0;
      Run_n      <= 1'b1;
      Continue_n <= 1'b1;
      err        <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      if (accept_start) begin
        pc_q     <= '0;
        err      <= 1'b0;
        pass_cnt <= '0;
        fail_cnt <= '0;
      end
      if (pc_inc)   pc_q  <= pc_q + ADDR_W'(1);
      if (cnt_load) cnt_q <= (op == OP_WAIT) ? arg : DATA_W'(PULSE_LEN);
      else if (cnt_dec) cnt_q <= cnt_q - DATA_W'(1);
      if (do_set)   S_out <= arg;
      if (run_lo)   Run_n      <= 1'b0;
      if (cont_lo)  Continue_n <= 1'b0;
      if (btn_release) begin
        Run_n      <= 1'b1;
        Continue_n <= 1'b1;
      end
      if (do_check && !check_fail) pass_cnt <= sat_inc(pass_cnt);
      if (check_fail || do_illegal) fail_cnt <= sat_inc(fail_cnt);
      if (do_illegal) err <= 1'b1;
    end
  end

`ifdef STIM_FAIL_CAPTURE_EN
  logic fail_seen_q;

  // Only the first failure of a run is captured; start re-arms it.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fail_seen_q <= 1'b0;
      fail_idx    <= '0;
      fail_obs    <= '0;
    end else if (accept_start) begin
      fail_seen_q <= 1'b0;
      fail_idx    <= '0;
      fail_obs    <= '0;
    end else if ((check_fail || do_illegal) && !fail_seen_q) begin
      fail_seen_q <= 1'b1;
      fail_idx    <= pc_q;
      fail_obs    <= do_illegal ? '0 : obs;
    end
  end
`endif

endmodule

// File: tb/tb_slc3_stim_sequencer.sv
// ---------------------------------------------------------------------------
// tb_slc3_stim_sequencer
//
// Directed self-checking bench for slc3_stim_sequencer. Expected values are
// pushed to a scoreboard queue before each scenario runs and popped in
// order as the corresponding DUT outputs are sampled (on the falling edge).
// DEPTH is raised to 320 so a single run can hold more than 255 failing
// CHECKs and reach counter saturation.
// ---------------------------------------------------------------------------
module tb_slc3_stim_sequencer;

  localparam int DATA_W    = 16;
  localparam int DEPTH     = 320;
  localparam int PULSE_LEN = 10;
  localparam int AW        = $clog2(DEPTH);

  localparam logic [2:0] OP_END        = 3'd0;
  localparam logic [2:0] OP_WAIT       = 3'd1;
  localparam logic [2:0] OP_SET_SW     = 3'd2;
  localparam logic [2:0] OP_PULSE_CONT = 3'd3;
  localparam logic [2:0] OP_PULSE_RUN  = 3'd4;
  localparam logic [2:0] OP_CHECK      = 3'd5;

  logic              Clk;
  logic              Reset;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W+2:0] wr_data;
  logic              start;
  logic [DATA_W-1:0] obs;
  logic [DATA_W-1:0] S_out;
  logic              Run_n;
  logic              Continue_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        pass_cnt;
  logic [7:0]        fail_cnt;
  logic [AW-1:0]     step_idx;
`ifdef STIM_FAIL_CAPTURE_EN
  logic [AW-1:0]     fail_idx;
  logic [DATA_W-1:0] fail_obs;
`endif

  slc3_stim_sequencer #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .PULSE_LEN(PULSE_LEN)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .obs       (obs),
    .S_out     (S_out),
    .Run_n     (Run_n),
    .Continue_n(Continue_n),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .step_idx  (step_idx)
`ifdef STIM_FAIL_CAPTURE_EN
    ,
    .fail_idx  (fail_idx),
    .fail_obs  (fail_obs)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Scoreboard
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] observed);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.val)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, observed, e.val);
      end
    end
  endtask

  // Run measurements, all in cycles counted from the cycle after the
  // accepting start edge (cycle 1 = first FETCH).
  int run_cyc, run_low, cont_low, run_first, cont_first, sw_first;
  logic busy_at1, timed_out;

  task automatic write_entry(input int addr, input logic [2:0] op,
                             input logic [15:0] arg);
    @(negedge Clk);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = {op, arg};
    @(negedge Clk);
    wr_en   = 1'b0;
  endtask

  // Start a run and follow it until done, with a cycle budget. When
  // inject_at is nonzero, a start pulse and a write to entry 1 are driven
  // in that cycle of the run.
  task automatic run_and_wait(input int budget, input int inject_at);
    run_low = 0; cont_low = 0; run_first = 0; cont_first = 0; sw_first = 0;
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start    = 1'b0;
    run_cyc  = 1;
    busy_at1 = busy;
    while (!done && run_cyc < budget) begin
      if (run_cyc == inject_at) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = AW'(1);
        wr_data = {OP_SET_SW, 16'h1234};
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (!Run_n) begin
        run_low++;
        if (run_first == 0) run_first = run_cyc;
      end
      if (!Continue_n) begin
        cont_low++;
        if (cont_first == 0) cont_first = run_cyc;
      end
      if (S_out == 16'h0031 && sw_first == 0) sw_first = run_cyc;
      @(negedge Clk);
      run_cyc++;
    end
    start     = 1'b0;
    wr_en     = 1'b0;
    timed_out = !done;
  endtask

  initial begin
    Reset   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    obs     = '0;

    // Reset held for three cycles
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    expect_val("rst_s_out", 0);
    expect_val("rst_run_n", 1);
    expect_val("rst_cont_n", 1);
    expect_val("rst_busy", 0);
    expect_val("rst_done", 0);
    expect_val("rst_err", 0);
    expect_val("rst_pass", 0);
    expect_val("rst_fail", 0);
    expect_val("rst_step", 0);
    check(S_out); check(Run_n); check(Continue_n); check(busy); check(done);
    check(err); check(pass_cnt); check(fail_cnt); check(step_idx);
    Reset = 1'b1;

    // Switch / button / wait script
    write_entry(0, OP_SET_SW, 16'h0031);
    write_entry(1, OP_PULSE_RUN, 16'h0000);
    write_entry(2, OP_WAIT, 16'd200);
    write_entry(3, OP_SET_SW, 16'h0005);
    write_entry(4, OP_PULSE_CONT, 16'h0000);
    write_entry(5, OP_END, 16'h0000);
    expect_val("seq_timeout", 0);
    expect_val("seq_busy_at1", 1);
    expect_val("seq_done_cyc", 233);
    expect_val("seq_sw31_cyc", 3);
    expect_val("seq_run_first", 5);
    expect_val("seq_run_low", 10);
    expect_val("seq_cont_first", 221);
    expect_val("seq_cont_low", 10);
    expect_val("seq_s_out", 16'h0005);
    expect_val("seq_busy_end", 0);
    expect_val("seq_err", 0);
    expect_val("seq_step", 5);
    run_and_wait(1000, 0);
    check(timed_out); check(busy_at1); check(run_cyc); check(sw_first);
    check(run_first); check(run_low); check(cont_first); check(cont_low);
    check(S_out); check(busy); check(err); check(step_idx);

    // CHECK pass and fail
    obs = 16'hA0A0;
    write_entry(0, OP_CHECK, 16'hA0A0);
    write_entry(1, OP_CHECK, 16'hFFFF);
    write_entry(2, OP_END, 16'h0000);
    expect_val("chk_timeout", 0);
    expect_val("chk_done_cyc", 7);
    expect_val("chk_pass", 1);
    expect_val("chk_fail", 1);
    expect_val("chk_err", 0);
    expect_val("chk_step", 2);
`ifdef STIM_FAIL_CAPTURE_EN
    expect_val("chk_fail_idx", 1);
    expect_val("chk_fail_obs", 16'hA0A0);
`endif
    run_and_wait(100, 0);
    check(timed_out); check(run_cyc); check(pass_cnt); check(fail_cnt);
    check(err); check(step_idx);
`ifdef STIM_FAIL_CAPTURE_EN
    check(fail_idx); check(fail_obs);
`endif

    // Illegal opcode after a zero-length wait
    write_entry(0, OP_WAIT, 16'h0000);
    write_entry(1, 3'd7, 16'h0000);
    expect_val("ill_timeout", 0);
    expect_val("ill_done_cyc", 5);
    expect_val("ill_pass", 0);
    expect_val("ill_fail", 1);
    expect_val("ill_err", 1);
    expect_val("ill_done", 1);
    expect_val("ill_step", 1);
`ifdef STIM_FAIL_CAPTURE_EN
    expect_val("ill_fail_idx", 1);
    expect_val("ill_fail_obs", 0);
`endif
    run_and_wait(100, 0);
    check(timed_out); check(run_cyc); check(pass_cnt); check(fail_cnt);
    check(err); check(done); check(step_idx);
`ifdef STIM_FAIL_CAPTURE_EN
    check(fail_idx); check(fail_obs);
`endif

    // Full memory of failing CHECKs: fail_cnt saturates, no wrap
    for (int i = 0; i < DEPTH; i++) write_entry(i, OP_CHECK, 16'hFFFF);
    expect_val("sat_timeout", 0);
    expect_val("sat_done_cyc", 2 * DEPTH + 1);
    expect_val("sat_fail", 255);
    expect_val("sat_pass", 0);
    expect_val("sat_err", 0);
    expect_val("sat_step", DEPTH - 1);
    run_and_wait(2000, 0);
    check(timed_out); check(run_cyc); check(fail_cnt); check(pass_cnt);
    check(err); check(step_idx);

    // Full memory of SET_SW without END
    for (int i = 0; i < DEPTH; i++) write_entry(i, OP_SET_SW, 16'(i + 1));
    expect_val("full_timeout", 0);
    expect_val("full_done_cyc", 2 * DEPTH + 1);
    expect_val("full_s_out", DEPTH);
    expect_val("full_step", DEPTH - 1);
    expect_val("full_fail", 0);
    run_and_wait(2000, 0);
    check(timed_out); check(run_cyc); check(S_out); check(step_idx);
    check(fail_cnt);

    // Reset during the third low cycle of PULSE_CONT
    write_entry(0, OP_PULSE_CONT, 16'h0000);
    write_entry(1, OP_END, 16'h0000);
    expect_val("prst_cont_low", 0);
    expect_val("prst_cont_high", 1);
    expect_val("prst_busy", 0);
    expect_val("prst_done", 0);
    expect_val("prst_s_out", 0);
    expect_val("prst_step", 0);
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (4) @(negedge Clk);
    check(Continue_n);
    Reset = 1'b0;
    @(negedge Clk);
    check(Continue_n); check(busy); check(done); check(S_out); check(step_idx);
    Reset = 1'b1;

    // start and wr_en while busy are ignored
    write_entry(0, OP_WAIT, 16'd50);
    write_entry(1, OP_END, 16'h0000);
    expect_val("busy_timeout", 0);
    expect_val("busy_done_cyc", 55);
    expect_val("busy_s_out", 0);
    expect_val("busy_step", 1);
    expect_val("rerun_timeout", 0);
    expect_val("rerun_done_cyc", 55);
    expect_val("rerun_s_out", 0);
    run_and_wait(500, 10);
    check(timed_out); check(run_cyc); check(S_out); check(step_idx);
    run_and_wait(500, 0);
    check(timed_out); check(run_cyc); check(S_out);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
